rtc_bus_arbiter: RTL

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_arbiter_pkg.sv | 23 ++
 rtl/rtc_phase_timer.sv | 29 ++
 rtl/rtc_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter: FSM encoding, phase-counter width,
// default phase length and the phase reload helper.
package rtc_bus_arbiter_pkg;

    localparam int PHASE_CNT_W       = 4;
    localparam int PHASE_CYC_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP_A  = 3'd1,
        ST_STROBE_A = 3'd2,
        ST_SETUP_D  = 3'd3,
        ST_STROBE_D = 3'd4,
        ST_HOLD     = 3'd5,
        ST_DONE     = 3'd6
    } rtc_state_e;

    // The timer counts down to zero, so a phase of N cycles reloads N-1.
    function automatic logic [PHASE_CNT_W-1:0] phase_reload(input int unsigned cyc);
        return PHASE_CNT_W'(cyc - 32'd1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Load/expire down-counter timing one bus phase; expired is high while the count is zero.
module rtc_phase_timer
    import rtc_bus_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic                   expired
);

    logic [PHASE_CNT_W-1:0] cnt_r;

    // Phase counter: reload on phase entry, count down and stick at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - PHASE_CNT_W'(32'd1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Two-channel arbiter driving a multiplexed address/data RTC bus.
// Optional macro RTC_ARB_ROUND_ROBIN_EN: alternate simultaneous grants instead of ch1 priority.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int PHASE_CYC = PHASE_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       we0,
    input  logic       we1,
    output logic       grant0,
    output logic       grant1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       sel
);

    rtc_state_e state_r, state_nx;
    logic       any_req_s, take_s, win_s, expired_s, timer_load_s;
    logic       owner_r, owner_nx_s, we_r, we_nx_s;
    logic [7:0] addr_r, addr_nx_s, wdata_r, wdata_nx_s;
    logic       cs_n_s, rd_n_s, wr_n_s, a_d_s, oe_s, done_s;
    logic [7:0] out_s;

    assign any_req_s = req0 | req1;
    assign take_s    = (state_r == ST_IDLE) && any_req_s;

`ifdef RTC_ARB_ROUND_ROBIN_EN
    logic last_r;

    // Contention goes to the channel not served last.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~last_r;
        end else begin
            win_s = req1;
        end
    end

    // Remember which channel was granted most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (take_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign win_s = req1;
`endif

    assign owner_nx_s = take_s ? win_s : owner_r;
    assign addr_nx_s  = take_s ? (win_s ? addr1 : addr0) : addr_r;
    assign wdata_nx_s = take_s ? (win_s ? wdata1 : wdata0) : wdata_r;
    assign we_nx_s    = take_s ? (win_s ? we1 : we0) : we_r;

    // Request fields are frozen at grant; later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
            we_r    <= 1'b0;
        end else begin
            owner_r <= owner_nx_s;
            addr_r  <= addr_nx_s;
            wdata_r <= wdata_nx_s;
            we_r    <= we_nx_s;
        end
    end

    assign timer_load_s = take_s ||
                          (expired_s && (state_r inside {ST_SETUP_A, ST_STROBE_A,
                                                         ST_SETUP_D, ST_STROBE_D}));

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load_s),
        .load_val (phase_reload(PHASE_CYC)),
        .expired  (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic; DONE always lasts a single cycle.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE:     state_nx = any_req_s ? ST_SETUP_A  : ST_IDLE;
            ST_SETUP_A:  state_nx = expired_s ? ST_STROBE_A : ST_SETUP_A;
            ST_STROBE_A: state_nx = expired_s ? ST_SETUP_D  : ST_STROBE_A;
            ST_SETUP_D:  state_nx = expired_s ? ST_STROBE_D : ST_SETUP_D;
            ST_STROBE_D: state_nx = expired_s ? ST_HOLD     : ST_STROBE_D;
            ST_HOLD:     state_nx = expired_s ? ST_DONE     : ST_HOLD;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the upcoming state so they can be registered without lag.
    always_comb begin
        cs_n_s = 1'b1;
        rd_n_s = 1'b1;
        wr_n_s = 1'b1;
        a_d_s  = 1'b1;
        oe_s   = 1'b0;
        out_s  = 8'h00;
        done_s = 1'b0;
        case (state_nx)
            ST_SETUP_A: begin
                cs_n_s = 1'b0;
                a_d_s  = 1'b0;
                oe_s   = 1'b1;
                out_s  = addr_nx_s;
            end
            ST_STROBE_A: begin
                cs_n_s = 1'b0;
                a_d_s  = 1'b0;
                oe_s   = 1'b1;
                out_s  = addr_nx_s;
                wr_n_s = 1'b0;
            end
            ST_SETUP_D: begin
                cs_n_s = 1'b0;
            end
            ST_STROBE_D: begin
                cs_n_s = 1'b0;
                if (we_nx_s) begin
                    wr_n_s = 1'b0;
                    oe_s   = 1'b1;
                    out_s  = wdata_nx_s;
                end else begin
                    rd_n_s = 1'b0;
                end
            end
            ST_HOLD: begin
                cs_n_s = 1'b0;
                oe_s   = we_nx_s;
                if (we_nx_s) begin
                    out_s = wdata_nx_s;
                end else begin
                    out_s = 8'h00;
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                cs_n_s = 1'b1;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant0   <= 1'b0;
            grant1   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            sel      <= 1'b0;
            rtc_cs_n <= 1'b1;
            rtc_rd_n <= 1'b1;
            rtc_wr_n <= 1'b1;
            rtc_a_d  <= 1'b1;
            ad_oe    <= 1'b0;
            ad_out   <= 8'h00;
        end else begin
            grant0   <= (state_nx != ST_IDLE) && !owner_nx_s;
            grant1   <= (state_nx != ST_IDLE) &&  owner_nx_s;
            done0    <= done_s && !owner_nx_s;
            done1    <= done_s &&  owner_nx_s;
            sel      <= owner_nx_s;
            rtc_cs_n <= cs_n_s;
            rtc_rd_n <= rd_n_s;
            rtc_wr_n <= wr_n_s;
            rtc_a_d  <= a_d_s;
            ad_oe    <= oe_s;
            ad_out   <= out_s;
        end
    end

    // Read data is sampled on the final read-strobe cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 8'h00;
        end else if ((state_r == ST_STROBE_D) && expired_s && !we_r) begin
            rdata <= ad_in;
        end else begin
            rdata <= rdata;
        end
    end

endmodule
